// File: rtl/decoder_n_scan.sv
// decoder_n_scan
//   N-to-2**N one-hot decoder with two modes of operation:
//     - direct: y follows addr with one clock of latency.
//     - scan:   starting at addr, each output bit is lit for DWELL cycles in
//               turn, wrapping from the top bit back to bit 0.
//   Every output comes straight from a flop. The combinational logic computes
//   the next value of each output, so no input has a path to an output
//   without passing through a register.
//
// Parameters
//   N      address width; y is 2**N bits wide (1..6)
//   DWELL  cycles each output is held while scanning (1..255)
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   en_n   active-low enable; while scanning, 1 pauses the scan
//   mode   0 = direct decode, 1 = scan
//   addr   decode address (direct) or scan start index (scan)
//   start  single-cycle pulse that begins a scan
//   stop   single-cycle pulse that ends a scan; wins over start
//   y      registered one-hot (or all-zero) decoded output
//   valid  high when y carries a one-hot code
//   busy   high while in the SCAN state, including while paused
//   wrap   one-cycle pulse when the scan index goes from 2**N-1 to 0
module decoder_n_scan #(
    parameter int N     = 2,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_n,
    input  logic             mode,
    input  logic [N-1:0]     addr,
    input  logic             start,
    input  logic             stop,
    output logic [2**N-1:0]  y,
    output logic             valid,
    output logic             busy,
    output logic             wrap
);

    localparam int             W          = 2**N;
    localparam logic [7:0]     DWELL_LAST = 8'(DWELL - 1);
    localparam logic [N-1:0]   IDX_LAST   = {N{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   idx_reg, idx_next;
    logic [7:0]     dcnt_reg, dcnt_next;

    // High on the edge where the scan index steps to its successor.
    logic           advance;
    // A scan may only be launched while enabled, in scan mode, and without
    // a simultaneous stop.
    logic           scan_go;

    logic [N-1:0]   sel;
    logic           drive;
    logic [W-1:0]   dec;
    logic [W-1:0]   y_next;
    logic           valid_next;
    logic           busy_next;
    logic           wrap_next;

    assign scan_go = ~en_n & mode & start & ~stop;

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            dcnt_reg  <= '0;
            y         <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            dcnt_reg  <= dcnt_next;
            y         <= y_next;
            valid     <= valid_next;
            busy      <= busy_next;
            wrap      <= wrap_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        dcnt_next  = dcnt_reg;
        advance    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (scan_go) begin
                    state_next = SCAN;
                    idx_next   = addr;
                    dcnt_next  = '0;
                end else if (!en_n && !mode) begin
                    state_next = DIRECT;
                end
            end

            DIRECT: begin
                if (en_n) begin
                    state_next = IDLE;
                end else if (mode) begin
                    // Scan mode without a clean start falls back to IDLE,
                    // which then waits for a start pulse.
                    if (scan_go) begin
                        state_next = SCAN;
                        idx_next   = addr;
                        dcnt_next  = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            SCAN: begin
                if (stop || !mode) begin
                    state_next = IDLE;
                end else if (!en_n) begin
                    // While paused (en_n=1) idx and dcnt are left frozen.
                    if (dcnt_reg == DWELL_LAST) begin
                        dcnt_next = '0;
                        idx_next  = idx_reg + N'(1);
                        advance   = 1'b1;
                    end else begin
                        dcnt_next = dcnt_reg + 8'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        sel        = addr;
        drive      = 1'b0;
        busy_next  = 1'b0;
        wrap_next  = 1'b0;

        case (state_next)
            DIRECT: begin
                sel   = addr;
                drive = 1'b1;
            end
            SCAN: begin
                sel       = idx_next;
                drive     = ~en_n;
                busy_next = 1'b1;
                wrap_next = advance & (idx_reg == IDX_LAST);
            end
            default: begin
                sel   = addr;
                drive = 1'b0;
            end
        endcase

        y_next     = drive ? dec : '0;
        valid_next = drive;
    end

    // One-hot decode of the selected index.
    for (genvar gi = 0; gi < W; gi++) begin : g_dec
        assign dec[gi] = (sel == N'(gi));
    end

endmodule

// File: doc/decoder_n_scan.md
DECODER_N_SCAN -- requirements
Module: decoder_n_scan

Interface
REQ-001 The module SHALL have parameter N, default 2, meaning address width; output width is 2**N; legal range 1..6.
REQ-002 The module SHALL have parameter DWELL, default 1, meaning clock cycles each output is held in scan mode; legal range 1..255.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port en_n, input, 1, active-low enable (1 = disabled).
REQ-006 The module SHALL have port mode, input, 1, 0 = direct decode, 1 = scan.
REQ-007 The module SHALL have port addr, input, N, decode address in direct mode and start index in scan mode.
REQ-008 The module SHALL have port start, input, 1, single-cycle pulse that begins a scan.
REQ-009 The module SHALL have port stop, input, 1, single-cycle pulse that ends a scan.
REQ-010 The module SHALL have port y, output, 2**N, registered one-hot (or all-zero) decoded output.
REQ-011 The module SHALL have port valid, output, 1, high when y carries a one-hot code.
REQ-012 The module SHALL have port busy, output, 1, high while in SCAN state.
REQ-013 The module SHALL have port wrap, output, 1, one-cycle pulse when the scan index wraps from 2**N-1 to 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, DIRECT, SCAN; it holds an index register idx (N bits) and dwell counter dcnt (8 bits).
REQ-015 IDLE: y=0, valid=0; en_n=0 and mode=0 -> DIRECT; en_n=0, mode=1 and start=1 -> SCAN with idx<=addr, dcnt<=0; otherwise stay.
REQ-016 DIRECT: y<=1<<addr every cycle (1-cycle latency from addr to y), valid=1; en_n=1 -> IDLE with y<=0; mode=1 and start=1 -> SCAN (idx<=addr); mode=1 without start -> IDLE.
REQ-017 SCAN: y=1<<idx, valid=1, busy=1; dcnt increments each enabled cycle; when dcnt==DWELL-1, dcnt<=0 and idx<=idx+1 modulo 2**N.
REQ-018 The wrap pulse SHALL assert in the cycle y changes from bit 2**N-1 to bit 0, for exactly one cycle.
REQ-019 In SCAN, en_n=1 SHALL pause: idx and dcnt frozen, y=0, valid=0, busy stays 1; on en_n=0 the scan resumes at the frozen idx/dcnt.
REQ-020 In SCAN, stop=1 or mode=0 SHALL exit to IDLE on the next edge with y=0, valid=0, busy=0, wrap=0.
REQ-021 start and stop asserted in the same cycle: stop SHALL win (no scan starts; a running scan stops).
REQ-022 start while already in SCAN SHALL be ignored.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-024 For N=1 the index SHALL toggle 0,1,0,... with wrap on each return to 0.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, y=0, valid=0, busy=0, wrap=0, idx=0, dcnt=0, regardless of clk.
REQ-026 Reset asserted mid-scan SHALL abort the scan; after release the block requires a new start to scan.
REQ-027 After rst release the first state change SHALL occur no earlier than the first rising clk edge.

Verification (N=2, DWELL=2 unless stated)
REQ-028 Direct sweep: en_n=0, mode=0, addr=0,1,2,3 each held 2 cycles -> y=0001,0010,0100,1000 one cycle after each addr change, valid=1.
REQ-029 Disable: in DIRECT addr=2, then en_n=1 -> y=0000, valid=0 next cycle; en_n=0 -> y=0100 one cycle after returning to DIRECT.
REQ-030 Scan with wrap: mode=1, addr=2, start pulse -> y=0100 x2, 1000 x2, 0001 x2 (wrap=1 in first 0001 cycle), 0010 x2, busy=1 throughout.
REQ-031 Pause/resume: during scan at y=1000 after 1 dwell cycle, en_n=1 for 3 cycles -> y=0000, busy=1; en_n=0 -> y=1000 for 1 more cycle then 0001.
REQ-032 Collision and stop: start and stop same cycle in IDLE -> stays IDLE; stop mid-scan -> y=0000, busy=0 next cycle.
REQ-033 Async reset mid-scan: rst pulse between clk edges -> all outputs 0 immediately; DWELL=1, N=3 scan then runs 8-cycle wrap period.
